alu_step_sequencer: RTL and testbench

Parametrised control-step generator for the bus-based CPU datapath. It replaces hand-driven per-state strobes with a hardware FSM. It accepts one register-register ALU instruction (op, Ra, Rb, Rc), then sequences fetch (T0–T2) and execute (T3–T5/T6) by asserting the datapath's register in/out enables, Y/Z/HI/LO loads, memory read and ALU select. It sits between the instruction issue logic (or a bench) and `CPU_Datapath`. It adds a memory-ready handshake with timeout, a 64-bit result path to HI/LO, and illegal-index detection.

---
 rtl/alu_step_sequencer_pkg.sv | 81 ++++++++
 rtl/alu_step_sequencer_if.sv | 45 ++++
 rtl/alu_step_sequencer_dec.sv | 19 +
 rtl/alu_step_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_step_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_step_sequencer_pkg.sv
// Shared types, ALU op constants and decode helpers for the ALU step sequencer.
package cpu_ctrl_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'h01;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 5'h0E;
  localparam logic [ALU_OP_W-1:0] ALU_DIV = 5'h0F;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_DONE = 4'd8
  } state_e;

  // Scalar datapath strobes, grouped so they can be decoded and registered together.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlo_out;
    logic zhi_out;
    logic lo_in;
    logic hi_in;
  } strobe_t;

  // Multiply and divide produce a 64-bit result that lands in HI/LO.
  function automatic logic is_wide_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

  // Scalar strobes owned by each control step; register enables are decoded separately.
  function automatic strobe_t decode_strobes(input state_e st, input logic wide);
    strobe_t s;
    s = '0;
    case (st)
      ST_T0: begin
        s.pc_out = 1'b1;
        s.mar_in = 1'b1;
        s.inc_pc = 1'b1;
      end
      ST_T1: begin
        s.read   = 1'b1;
        s.mdr_in = 1'b1;
      end
      ST_T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      ST_T3: s.y_in = 1'b1;
      ST_T4: s.z_in = 1'b1;
      ST_T5: begin
        s.zlo_out = 1'b1;
        if (wide) begin
          s.lo_in = 1'b1;
        end else begin
          s.lo_in = 1'b0;
        end
      end
      ST_T6: begin
        s.zhi_out = 1'b1;
        s.hi_in   = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_step_sequencer_if.sv
// Issue/handshake and datapath-strobe bundle between the issuer and the step sequencer.
interface alu_step_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int SEL_W    = 5
);
  logic                start;
  logic [SEL_W-1:0]    op;
  logic [IDX_W-1:0]    ra;
  logic [IDX_W-1:0]    rb;
  logic [IDX_W-1:0]    rc;
  logic                mem_rdy;

  logic                busy;
  logic                done;
  logic                err;
  logic                pc_out;
  logic                mar_in;
  logic                inc_pc;
  logic                read;
  logic                mdr_in;
  logic                mdr_out;
  logic                ir_in;
  logic                y_in;
  logic                z_in;
  logic                zlo_out;
  logic                zhi_out;
  logic                lo_in;
  logic                hi_in;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic [SEL_W-1:0]    alu_sel;

  modport master (
    output start, op, ra, rb, rc, mem_rdy,
    input  busy, done, err, pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_in, reg_out, alu_sel
  );

  modport slave (
    input  start, op, ra, rb, rc, mem_rdy,
    output busy, done, err, pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_in, reg_out, alu_sel
  );
endinterface

// File: rtl/alu_step_sequencer_dec.sv
// Register index to one-hot enable decoder; all-zero when disabled or index out of range.
module reg_onehot_dec #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // An out-of-range index matches no bit position, so it decodes to zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Control-step FSM that sequences fetch and execute of one register-register ALU instruction.
module alu_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int IDX_W       = $clog2(NUM_REGS),
  parameter int SEL_W       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                clk,
  input logic                clr,
  alu_step_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_r, state_s;
  logic [SEL_W-1:0]   op_r, op_s;
  logic [IDX_W-1:0]   ra_r, ra_s, rb_r, rb_s, rc_r, rc_s;
  logic               err_r, err_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;

  logic               ra_bad_s, rb_bad_s, rc_bad_s;
  logic               wide_s;
  strobe_t            strobe_s, strobe_r;
  logic [IDX_W-1:0]   out_idx_s;
  logic               out_en_s, in_en_s;
  logic [NUM_REGS-1:0] reg_in_s, reg_out_s, reg_in_r, reg_out_r;
  logic [SEL_W-1:0]   alu_sel_s, alu_sel_r;
  logic               busy_r, done_r, err_out_r;

  // Index legality only needs checking when the index field can encode unused registers.
  generate
    if (NUM_REGS < (1 << IDX_W)) begin : g_range_chk
      assign ra_bad_s = (bus.ra >= IDX_W'(NUM_REGS));
      assign rb_bad_s = (bus.rb >= IDX_W'(NUM_REGS));
      assign rc_bad_s = (bus.rc >= IDX_W'(NUM_REGS));
    end else begin : g_full_range
      assign ra_bad_s = 1'b0;
      assign rb_bad_s = 1'b0;
      assign rc_bad_s = 1'b0;
    end
  endgenerate

  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Next-state, field-latch and memory-wait counter logic.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    ra_s    = ra_r;
    rb_s    = rb_r;
    rc_s    = rc_r;
    err_s   = err_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          op_s = bus.op;
          ra_s = bus.ra;
          rb_s = bus.rb;
          rc_s = bus.rc;
          if (ra_bad_s || rb_bad_s || rc_bad_s) begin
            state_s = ST_DONE;
            err_s   = 1'b1;
          end else begin
            state_s = ST_T0;
            err_s   = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_T0: begin
        state_s = ST_T1;
        cnt_s   = '0;
      end
      ST_T1: begin
        if (bus.mem_rdy) begin
          state_s = ST_T2;
        end else if (cnt_inc_s == CNT_W'(MEM_TIMEOUT)) begin
          state_s = ST_DONE;
          err_s   = 1'b1;
          cnt_s   = cnt_inc_s;
        end else begin
          cnt_s   = cnt_inc_s;
        end
      end
      ST_T2: state_s = ST_T3;
      ST_T3: state_s = ST_T4;
      ST_T4: state_s = ST_T5;
      ST_T5: begin
        if (is_wide_op(ALU_OP_W'(op_r))) begin
          state_s = ST_T6;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_T6:   state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Moore decode of the upcoming state so every output can be registered.
  always_comb begin
    wide_s    = is_wide_op(ALU_OP_W'(op_s));
    strobe_s  = decode_strobes(state_s, wide_s);
    out_en_s  = (state_s == ST_T3) || (state_s == ST_T4);
    in_en_s   = (state_s == ST_T5) && !wide_s;
    if (state_s == ST_T3) begin
      out_idx_s = rb_s;
    end else begin
      out_idx_s = rc_s;
    end
    if (state_s == ST_T4) begin
      alu_sel_s = op_s;
    end else begin
      alu_sel_s = '0;
    end
  end

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_out (
    .idx    (out_idx_s),
    .en     (out_en_s),
    .onehot (reg_out_s)
  );

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_in (
    .idx    (ra_s),
    .en     (in_en_s),
    .onehot (reg_in_s)
  );

  // State, latched fields, counter and registered outputs; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r   <= ST_IDLE;
      op_r      <= '0;
      ra_r      <= '0;
      rb_r      <= '0;
      rc_r      <= '0;
      err_r     <= 1'b0;
      cnt_r     <= '0;
      strobe_r  <= '0;
      reg_in_r  <= '0;
      reg_out_r <= '0;
      alu_sel_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_out_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      ra_r      <= ra_s;
      rb_r      <= rb_s;
      rc_r      <= rc_s;
      err_r     <= err_s;
      cnt_r     <= cnt_s;
      strobe_r  <= strobe_s;
      reg_in_r  <= reg_in_s;
      reg_out_r <= reg_out_s;
      alu_sel_r <= alu_sel_s;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= (state_s == ST_DONE);
      err_out_r <= (state_s == ST_DONE) && err_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_out_r;
  assign bus.pc_out  = strobe_r.pc_out;
  assign bus.mar_in  = strobe_r.mar_in;
  assign bus.inc_pc  = strobe_r.inc_pc;
  assign bus.read    = strobe_r.read;
  assign bus.mdr_in  = strobe_r.mdr_in;
  assign bus.mdr_out = strobe_r.mdr_out;
  assign bus.ir_in   = strobe_r.ir_in;
  assign bus.y_in    = strobe_r.y_in;
  assign bus.z_in    = strobe_r.z_in;
  assign bus.zlo_out = strobe_r.zlo_out;
  assign bus.zhi_out = strobe_r.zhi_out;
  assign bus.lo_in   = strobe_r.lo_in;
  assign bus.hi_in   = strobe_r.hi_in;
  assign bus.reg_in  = reg_in_r;
  assign bus.reg_out = reg_out_r;
  assign bus.alu_sel = alu_sel_r;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Self-checking bench: two sequencer instances (16 regs/timeout 15, 12 regs/timeout 4)
// checked cycle by cycle against an expected-trace model built from the step rules.
module tb_alu_step_sequencer;

  // Strobe masks, bit order {pc_out,mar_in,inc_pc,read,mdr_in,mdr_out,ir_in,y_in,z_in,zlo_out,zhi_out,lo_in,hi_in}
  localparam logic [12:0] M_PC_OUT  = 13'h1000;
  localparam logic [12:0] M_MAR_IN  = 13'h0800;
  localparam logic [12:0] M_INC_PC  = 13'h0400;
  localparam logic [12:0] M_READ    = 13'h0200;
  localparam logic [12:0] M_MDR_IN  = 13'h0100;
  localparam logic [12:0] M_MDR_OUT = 13'h0080;
  localparam logic [12:0] M_IR_IN   = 13'h0040;
  localparam logic [12:0] M_Y_IN    = 13'h0020;
  localparam logic [12:0] M_Z_IN    = 13'h0010;
  localparam logic [12:0] M_ZLO_OUT = 13'h0008;
  localparam logic [12:0] M_ZHI_OUT = 13'h0004;
  localparam logic [12:0] M_LO_IN   = 13'h0002;
  localparam logic [12:0] M_HI_IN   = 13'h0001;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] stb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  sel;
  } obs_t;

  logic clk;
  logic clr;
  int   tests;
  int   fails;
  obs_t exp_q[$];

  alu_step_sequencer_if #(.NUM_REGS(16)) ifa ();
  alu_step_sequencer_if #(.NUM_REGS(12)) ifb ();

  alu_step_sequencer #(.NUM_REGS(16), .MEM_TIMEOUT(15)) dut_a (.clk(clk), .clr(clr), .bus(ifa.slave));
  alu_step_sequencer #(.NUM_REGS(12), .MEM_TIMEOUT(4))  dut_b (.clk(clk), .clr(clr), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.busy = ifa.busy; o.done = ifa.done; o.err = ifa.err;
      o.stb  = {ifa.pc_out, ifa.mar_in, ifa.inc_pc, ifa.read, ifa.mdr_in, ifa.mdr_out, ifa.ir_in,
                ifa.y_in, ifa.z_in, ifa.zlo_out, ifa.zhi_out, ifa.lo_in, ifa.hi_in};
      o.rin  = ifa.reg_in; o.rout = ifa.reg_out; o.sel = ifa.alu_sel;
    end else begin
      o.busy = ifb.busy; o.done = ifb.done; o.err = ifb.err;
      o.stb  = {ifb.pc_out, ifb.mar_in, ifb.inc_pc, ifb.read, ifb.mdr_in, ifb.mdr_out, ifb.ir_in,
                ifb.y_in, ifb.z_in, ifb.zlo_out, ifb.zhi_out, ifb.lo_in, ifb.hi_in};
      o.rin  = {4'h0, ifb.reg_in}; o.rout = {4'h0, ifb.reg_out}; o.sel = ifb.alu_sel;
    end
    return o;
  endfunction

  task automatic set_in(input int d, input logic st, input logic [4:0] op,
                        input int ra, input int rb, input int rc, input logic rdy);
    if (d == 0) begin
      ifa.start = st; ifa.op = op; ifa.ra = 4'(ra); ifa.rb = 4'(rb); ifa.rc = 4'(rc); ifa.mem_rdy = rdy;
    end else begin
      ifb.start = st; ifb.op = op; ifb.ra = 4'(ra); ifb.rb = 4'(rb); ifb.rc = 4'(rc); ifb.mem_rdy = rdy;
    end
  endtask

  function automatic void push(input logic b, input logic d, input logic e, input logic [12:0] s,
                               input logic [15:0] ri, input logic [15:0] ro, input logic [4:0] sel);
    obs_t o;
    o.busy = b; o.done = d; o.err = e; o.stb = s; o.rin = ri; o.rout = ro; o.sel = sel;
    exp_q.push_back(o);
  endfunction

  // Expected per-cycle outputs from acceptance until back in IDLE.
  function automatic void build(input logic [4:0] op, input int ra, input int rb, input int rc,
                                input int waits, input int nregs, input int tmo);
    logic [15:0] one;
    one = 16'h0001;
    exp_q.delete();
    if (ra >= nregs || rb >= nregs || rc >= nregs) begin
      push(1'b1, 1'b1, 1'b1, 13'h0, 16'h0, 16'h0, 5'h0);
    end else begin
      push(1'b1, 1'b0, 1'b0, M_PC_OUT | M_MAR_IN | M_INC_PC, 16'h0, 16'h0, 5'h0);
      if (waits >= tmo) begin
        for (int i = 0; i < tmo; i++) push(1'b1, 1'b0, 1'b0, M_READ | M_MDR_IN, 16'h0, 16'h0, 5'h0);
        push(1'b1, 1'b1, 1'b1, 13'h0, 16'h0, 16'h0, 5'h0);
      end else begin
        for (int i = 0; i <= waits; i++) push(1'b1, 1'b0, 1'b0, M_READ | M_MDR_IN, 16'h0, 16'h0, 5'h0);
        push(1'b1, 1'b0, 1'b0, M_MDR_OUT | M_IR_IN, 16'h0, 16'h0, 5'h0);
        push(1'b1, 1'b0, 1'b0, M_Y_IN, 16'h0, one << rb, 5'h0);
        push(1'b1, 1'b0, 1'b0, M_Z_IN, 16'h0, one << rc, op);
        if (op == 5'h0E || op == 5'h0F) begin
          push(1'b1, 1'b0, 1'b0, M_ZLO_OUT | M_LO_IN, 16'h0, 16'h0, 5'h0);
          push(1'b1, 1'b0, 1'b0, M_ZHI_OUT | M_HI_IN, 16'h0, 16'h0, 5'h0);
        end else begin
          push(1'b1, 1'b0, 1'b0, M_ZLO_OUT, one << ra, 16'h0, 5'h0);
        end
        push(1'b1, 1'b1, 1'b0, 13'h0, 16'h0, 16'h0, 5'h0);
      end
    end
    push(1'b0, 1'b0, 1'b0, 13'h0, 16'h0, 16'h0, 5'h0);
  endfunction

  // Issue one instruction and compare every cycle; optionally assert clr after entry abort_at.
  task automatic run_instr(input int d, input string nm, input logic [4:0] op, input int ra,
                           input int rb, input int rc, input int waits, input int abort_at);
    obs_t got;
    int   nregs;
    int   tmo;
    nregs = (d == 0) ? 16 : 12;
    tmo   = (d == 0) ? 15 : 4;
    build(op, ra, rb, rc, waits, nregs, tmo);
    set_in(d, 1'b1, op, ra, rb, rc, 1'b0);
    @(posedge clk); #1;
    for (int idx = 0; idx < exp_q.size(); idx++) begin
      if (idx > 0) begin
        @(posedge clk); #1;
      end
      got = get_obs(d);
      tests++;
      if (got !== exp_q[idx]) begin
        fails++;
        $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp_q[idx]);
      end
      if (idx == abort_at) begin
        clr = 1'b1;
        set_in(d, 1'b0, 5'h0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0;
        got = get_obs(d);
        tests++;
        if (got !== obs_t'(0)) begin
          fails++;
          $display("FAIL %s_abort: got %h expected 0", nm, got);
        end
        return;
      end
      if (idx + 1 < exp_q.size()) begin
        // Noise on start while busy must be ignored.
        set_in(d, 1'($urandom_range(0, 1)), 5'($urandom), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), idx >= 1 + waits);
      end else begin
        set_in(d, 1'b0, 5'h0, 0, 0, 0, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    obs_t got;
    clr = 1'b1;
    set_in(0, 1'b1, 5'h01, 1, 2, 3, 1'b1);
    set_in(1, 1'b1, 5'h01, 1, 2, 3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      got = get_obs(d);
      tests++;
      if (got !== obs_t'(0)) begin
        fails++;
        $display("FAIL reset_dut%0d: got %h expected 0", d, got);
      end
    end
    clr = 1'b0;
    set_in(0, 1'b0, 5'h0, 0, 0, 0, 1'b0);
    set_in(1, 1'b0, 5'h0, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_narrow_add();
    run_instr(0, "narrow_add", 5'h01, 0, 5, 4, 0, -1);
  endtask

  task automatic test_wide_mul();
    run_instr(0, "wide_mul", 5'h0E, 9, 3, 7, 0, -1);
    run_instr(0, "wide_div", 5'h0F, 2, 15, 0, 0, -1);
  endtask

  task automatic test_mem_wait();
    run_instr(0, "mem_wait", 5'h01, 6, 1, 2, 3, -1);
  endtask

  task automatic test_timeout();
    run_instr(1, "timeout", 5'h01, 1, 2, 3, 1000, -1);
    run_instr(1, "rdy_last_cycle", 5'h03, 11, 10, 0, 3, -1);
  endtask

  task automatic test_illegal();
    run_instr(1, "illegal_ra", 5'h01, 13, 2, 3, 0, -1);
    run_instr(1, "illegal_rc", 5'h0E, 0, 2, 12, 0, -1);
  endtask

  task automatic test_reset_mid();
    obs_t got;
    run_instr(0, "reset_mid", 5'h01, 3, 4, 5, 0, 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = get_obs(0);
      tests++;
      if (got !== obs_t'(0)) begin
        fails++;
        $display("FAIL reset_mid_idle[%0d]: got %h expected 0", i, got);
      end
    end
    run_instr(0, "after_reset", 5'h02, 7, 8, 9, 1, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      run_instr(0, "b2b_a", 5'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), -1);
    end
    for (int n = 0; n < 16; n++) begin
      run_instr(1, "b2b_b", 5'($urandom), int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
                int'($urandom_range(0, 13)), int'($urandom_range(0, 6)), -1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clr   = 1'b1;
    test_reset();
    test_narrow_add();
    test_wide_mul();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
